pic_ctrl_param: RTL

- Parametrised successor to the 8-input interrupt control logic: N_IRQ request lines, DATA_W-bit bus, fixed or rotating priority, automatic EOI.
- Runs an ICW1..ICW4 initialisation FSM, decodes OCW1/OCW2/OCW3, and arbitrates IRR & ~IMR against ISR under fully-nested priority.
- Sequences the two-pulse INTA handshake and drives the vector onto the data bus.
- Fully synchronous to clk. Bus and INTA strobes are sampled and edge-detected. Cascade operation is out of scope: ICW3 is stored but unused. 8086 mode only.

---
 rtl/pic_ctrl_param.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pic_ctrl_param.sv
// rtl/pic_ctrl_param.sv - parametrised programmable interrupt controller
// ICW init sequencing, OCW decode, fully-nested/rotating priority and two-pulse INTA vectoring.
module pic_ctrl_param #(
  parameter int N_IRQ  = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(N_IRQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic              a0,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              inta_n,
  output logic              int_o,
  output logic              init_done,
  output logic [N_IRQ-1:0]  isr_o
);
  typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} init_state_t;
  typedef enum logic [1:0] {ACK_IDLE, ACK_P1, ACK_P2} ack_state_t;

  init_state_t state_q, state_d;
  ack_state_t  ack_q;

  logic                    wr_prev, inta_prev;
  logic [N_IRQ-1:0]        irq_prev, irr, isr, imr;
  logic [IDX_W-1:0]        low_pri, win;
  logic                    win_valid, ltim, sngl, ic4, aeoi, rot_aeoi, rd_isr;
  logic [DATA_W-IDX_W-1:0] vec_base;
  logic [DATA_W-1:0]       icw3;

  logic             wr_act, wr_ev, icw1_ev, ready, ocw2_ev, ocw3_ev;
  logic             inta_fall, inta_rise, vec_drive, l_ok;
  logic [IDX_W-1:0] l_idx;

  assign wr_act    = !cs_n && !wr_n;
  assign wr_ev     = wr_act && !wr_prev;
  assign icw1_ev   = wr_ev && !a0 && din[4];
  assign ready     = (state_q == READY);
  assign ocw2_ev   = wr_ev && ready && !a0 && (din[4:3] == 2'b00);
  assign ocw3_ev   = wr_ev && ready && !a0 && (din[4:3] == 2'b01);
  assign inta_fall = ready && !inta_n && inta_prev;
  assign inta_rise = ready && inta_n && !inta_prev;
  assign vec_drive = (ack_q == ACK_P1 && inta_fall) || (ready && ack_q == ACK_P2 && !inta_n);
  assign l_idx     = din[IDX_W-1:0];
  assign l_ok      = int'(l_idx) < N_IRQ;
  assign init_done = ready;
  assign isr_o     = isr;

  logic [N_IRQ-1:0] req;
  logic             req_any, isr_any, int_cond;
  logic [IDX_W-1:0] req_idx, isr_idx;
  int               req_rank, isr_rank, rank;

  always_comb begin
    req      = irr & ~imr;
    req_any  = 1'b0;
    req_idx  = '0;
    req_rank = N_IRQ;
    isr_any  = 1'b0;
    isr_idx  = '0;
    isr_rank = N_IRQ;
    rank     = 0;
    for (int i = 0; i < N_IRQ; i++) begin
      // rank 0 is the line just after low_pri, i.e. the highest priority
      rank = i + N_IRQ - 1 - int'(low_pri);
      if (rank >= N_IRQ) rank = rank - N_IRQ;
      if (req[i] && rank < req_rank) begin
        req_rank = rank;
        req_idx  = IDX_W'(i);
        req_any  = 1'b1;
      end
      if (isr[i] && rank < isr_rank) begin
        isr_rank = rank;
        isr_idx  = IDX_W'(i);
        isr_any  = 1'b1;
      end
    end
    int_cond = req_any && (req_rank < isr_rank);
  end

  logic [N_IRQ-1:0] ack_set, eoi_clr, aeoi_clr, irr_d, isr_d;
  logic [IDX_W-1:0] low_pri_d;

  always_comb begin
    ack_set   = '0;
    eoi_clr   = '0;
    aeoi_clr  = '0;
    low_pri_d = low_pri;
    if (inta_fall && ack_q == ACK_IDLE && int_cond) ack_set[req_idx] = 1'b1;
    if (ocw2_ev) begin
      case (din[7:5])
        3'b001: if (isr_any) eoi_clr[isr_idx] = 1'b1;
        3'b011: if (l_ok) eoi_clr[l_idx] = 1'b1;
        3'b101: if (isr_any) begin
          eoi_clr[isr_idx] = 1'b1;
          low_pri_d        = isr_idx;
        end
        3'b111: if (l_ok) begin
          eoi_clr[l_idx] = 1'b1;
          low_pri_d      = l_idx;
        end
        3'b110: if (l_ok) low_pri_d = l_idx;
        default: ;
      endcase
    end
    if (inta_rise && ack_q == ACK_P2 && aeoi && win_valid) begin
      aeoi_clr[win] = 1'b1;
      if (rot_aeoi) low_pri_d = win;
    end
    // set beats clear on the same bit; a fresh edge survives its own acknowledge
    isr_d = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
    irr_d = ltim ? irq : ((irr & ~ack_set) | (irq & ~irq_prev));
  end

  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_data              = '0;
    rd_data[N_IRQ-1:0]   = a0 ? imr : (rd_isr ? isr : irr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= UNINIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (icw1_ev) begin
      state_d = W_ICW2;
    end else if (wr_ev && a0) begin
      case (state_q)
        W_ICW2:  state_d = !sngl ? W_ICW3 : (ic4 ? W_ICW4 : READY);
        W_ICW3:  state_d = ic4 ? W_ICW4 : READY;
        W_ICW4:  state_d = READY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_prev   <= 1'b0;
      inta_prev <= 1'b1;
      irq_prev  <= '0;
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      low_pri   <= IDX_W'(N_IRQ - 1);
      win       <= '0;
      win_valid <= 1'b0;
      ltim      <= 1'b0;
      sngl      <= 1'b0;
      ic4       <= 1'b0;
      aeoi      <= 1'b0;
      rot_aeoi  <= 1'b0;
      rd_isr    <= 1'b0;
      vec_base  <= '0;
      icw3      <= '0;
      ack_q     <= ACK_IDLE;
      int_o     <= 1'b0;
      dout      <= '0;
      dout_oe   <= 1'b0;
    end else begin
      wr_prev   <= wr_act;
      inta_prev <= inta_n;
      irq_prev  <= irq;
      if (icw1_ev) begin
        ltim     <= din[3];
        sngl     <= din[1];
        ic4      <= din[0];
        irr      <= '0;
        isr      <= '0;
        imr      <= '0;
        low_pri  <= IDX_W'(N_IRQ - 1);
        aeoi     <= 1'b0;
        rot_aeoi <= 1'b0;
        ack_q    <= ACK_IDLE;
        int_o    <= 1'b0;
        dout_oe  <= 1'b0;
      end else begin
        irr     <= irr_d;
        isr     <= isr_d;
        low_pri <= low_pri_d;
        if (wr_ev && a0) begin
          case (state_q)
            W_ICW2:  vec_base <= din[DATA_W-1:IDX_W];
            W_ICW3:  icw3 <= din;
            W_ICW4:  aeoi <= din[1];
            READY:   imr <= din[N_IRQ-1:0];
            default: ;
          endcase
        end
        if (ocw2_ev && din[6:5] == 2'b00) rot_aeoi <= din[7];
        if (ocw3_ev && din[1]) rd_isr <= din[0];
        case (ack_q)
          ACK_IDLE: if (inta_fall) begin
            win       <= int_cond ? req_idx : IDX_W'(N_IRQ - 1);
            win_valid <= int_cond;
            ack_q     <= ACK_P1;
          end
          ACK_P1:  if (inta_fall) ack_q <= ACK_P2;
          ACK_P2:  if (inta_rise) ack_q <= ACK_IDLE;
          default: ack_q <= ACK_IDLE;
        endcase
        int_o <= (inta_fall && ack_q == ACK_IDLE) ? 1'b0 : (ready && int_cond);
        if (vec_drive) begin
          dout    <= {vec_base, win};
          dout_oe <= 1'b1;
        end else if (ready && !cs_n && !rd_n) begin
          dout    <= rd_data;
          dout_oe <= 1'b1;
        end else begin
          dout_oe <= 1'b0;
        end
      end
    end
  end
endmodule
